// File: rtl/wb_mailbox_pkg.sv
// rtl/wb_mailbox_pkg.sv - register map, bit indices and bus FSM states for the WISHBONE mailbox
package wb_mailbox_pkg;

    typedef enum logic [1:0] {
        REG_DATA     = 2'd0,
        REG_STATUS   = 2'd1,
        REG_CTRL     = 2'd2,
        REG_RX_COUNT = 2'd3
    } reg_addr_e;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } bus_state_e;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_UDF   = 5;

    localparam int CT_TX_FLUSH       = 0;
    localparam int CT_RX_FLUSH       = 1;
    localparam int CT_IE_TX_EMPTY    = 2;
    localparam int CT_IE_RX_NONEMPTY = 3;

endpackage

// File: rtl/mailbox_fifo.sv
// rtl/mailbox_fifo.sv - synchronous first-word-fall-through byte FIFO with flush
module mailbox_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rptr];

    // Acceptance uses the registered flags only: a same-cycle pop never makes room for a push.
    assign w_push = push && !full && !flush;
    assign w_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/wb_mailbox_slave.sv
// rtl/wb_mailbox_slave.sv - 8-bit WISHBONE classic mailbox slave, TX/RX byte FIFOs to a valid/ready stream
// Optional interrupt logic and CTRL[3:2] enables are built when WB_MAILBOX_IRQ_EN is defined.
module wb_mailbox_slave
    import wb_mailbox_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [7:0]  BASE_ADDR  = 8'h80
) (
    input  logic       wb_clk_i,
    input  logic       wb_rstn_i,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    input  logic [7:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    bus_state_e    r_state;
    bus_state_e    w_next;
    reg_addr_e     w_reg;
    logic [7:0]    r_rdata;
    logic [7:0]    w_rdata;
    logic [7:0]    w_status;
    logic [7:0]    w_ctrl_rd;
    logic          r_tx_ovf;
    logic          r_rx_udf;
    logic          w_go;
    logic          w_wr;
    logic          w_rd;
    logic          w_tx_push;
    logic          w_rx_pop;
    logic          w_tx_flush;
    logic          w_rx_flush;
    logic          w_tx_full;
    logic          w_tx_empty;
    logic          w_rx_full;
    logic          w_rx_empty;
    logic [7:0]    w_rx_dout;
    logic [CW-1:0] w_rx_count;
    logic [CW-1:0] w_tx_count_unused;

    // All register side effects happen on the single IDLE->ACK edge.
    assign w_go  = (r_state == IDLE) && wb_cyc_i && wb_stb_i && (wb_adr_i[7:2] == BASE_ADDR[7:2]);
    assign w_wr  = w_go && wb_we_i;
    assign w_rd  = w_go && !wb_we_i;
    assign w_reg = reg_addr_e'(wb_adr_i[1:0]);

    assign w_tx_push  = w_wr && (w_reg == REG_DATA);
    assign w_rx_pop   = w_rd && (w_reg == REG_DATA);
    assign w_tx_flush = w_wr && (w_reg == REG_CTRL) && wb_dat_i[CT_TX_FLUSH];
    assign w_rx_flush = w_wr && (w_reg == REG_CTRL) && wb_dat_i[CT_RX_FLUSH];

    assign tx_valid = !w_tx_empty;
    assign rx_ready = !w_rx_full;

    mailbox_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rstn_i),
        .push  (w_tx_push),
        .pop   (tx_ready),
        .flush (w_tx_flush),
        .din   (wb_dat_i),
        .dout  (tx_data),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count_unused)
    );

    mailbox_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rstn_i),
        .push  (rx_valid),
        .pop   (w_rx_pop),
        .flush (w_rx_flush),
        .din   (rx_data),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    assign w_status = {2'b00, r_rx_udf, r_tx_ovf, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

`ifdef WB_MAILBOX_IRQ_EN
    logic r_ie_tx_empty;
    logic r_ie_rx_nonempty;
    logic r_irq;

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_ie_tx_empty    <= 1'b0;
            r_ie_rx_nonempty <= 1'b0;
            r_irq            <= 1'b0;
        end else begin
            if (w_wr && (w_reg == REG_CTRL)) begin
                r_ie_tx_empty    <= wb_dat_i[CT_IE_TX_EMPTY];
                r_ie_rx_nonempty <= wb_dat_i[CT_IE_RX_NONEMPTY];
            end
            r_irq <= (r_ie_tx_empty && w_tx_empty) || (r_ie_rx_nonempty && !w_rx_empty);
        end
    end

    assign irq       = r_irq;
    assign w_ctrl_rd = {4'b0000, r_ie_rx_nonempty, r_ie_tx_empty, 2'b00};
`else
    assign irq       = 1'b0;
    assign w_ctrl_rd = 8'h00;
`endif

    always_comb begin
        w_rdata = 8'h00;
        case (w_reg)
            REG_DATA:     w_rdata = w_rx_empty ? 8'h00 : w_rx_dout;
            REG_STATUS:   w_rdata = w_status;
            REG_CTRL:     w_rdata = w_ctrl_rd;
            REG_RX_COUNT: w_rdata = 8'(w_rx_count);
            default:      w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_rdata  <= 8'h00;
            r_tx_ovf <= 1'b0;
            r_rx_udf <= 1'b0;
        end else begin
            if (w_go) r_rdata <= wb_we_i ? 8'h00 : w_rdata;
            if (w_tx_push && w_tx_full)
                r_tx_ovf <= 1'b1;
            else if (w_wr && (w_reg == REG_STATUS) && wb_dat_i[ST_TX_OVF])
                r_tx_ovf <= 1'b0;
            if (w_rx_pop && w_rx_empty)
                r_rx_udf <= 1'b1;
            else if (w_wr && (w_reg == REG_STATUS) && wb_dat_i[ST_RX_UDF])
                r_rx_udf <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) r_state <= IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_go) w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        wb_ack_o = 1'b0;
        wb_dat_o = 8'h00;
        if (r_state == ACK) begin
            wb_ack_o = 1'b1;
            wb_dat_o = r_rdata;
        end
    end

endmodule

// File: tb/tb_wb_mailbox_slave.sv
// tb/tb_wb_mailbox_slave.sv - directed and random checks of wb_mailbox_slave against a queue model
module tb_wb_mailbox_slave;

    localparam int         DEPTH = 16;
    localparam logic [7:0] BASE  = 8'h80;
`ifdef WB_MAILBOX_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cyc = 1'b0, stb = 1'b0, we_i = 1'b0;
    logic [7:0] adr = 8'h00, dat = 8'h00;
    logic [7:0] dat_o;
    logic       ack;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic       irq;

    int total = 0;
    int bad = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit m_ovf = 0, m_udf = 0, m_ie_tx = 0, m_ie_rx = 0;

    always #5 clk = ~clk;

    wb_mailbox_slave #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .wb_clk_i  (clk),
        .wb_rstn_i (rst_n),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (we_i),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat),
        .wb_dat_o  (dat_o),
        .wb_ack_o  (ack),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .irq       (irq)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit exp_irq();
        return (m_ie_tx && tx_q.size() == 0) || (m_ie_rx && rx_q.size() != 0);
    endfunction

    task automatic bus(input bit w, input logic [1:0] off, input logic [7:0] d, output logic [7:0] q);
        cyc = 1'b1; stb = 1'b1; we_i = w; adr = BASE + {6'b0, off}; dat = d;
        tick();
        chk("ack_rise", ack, 1);
        q = dat_o;
        cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
        tick();
        chk("ack_fall", ack, 0);
    endtask

    task automatic wr_data(input logic [7:0] b);
        logic [7:0] q;
        bus(1'b1, 2'd0, b, q);
        if (tx_q.size() == DEPTH) m_ovf = 1;
        else tx_q.push_back(b);
        chk("irq", irq, exp_irq());
    endtask

    task automatic rd_data();
        logic [7:0] q, e;
        bus(1'b0, 2'd0, 8'h00, q);
        if (rx_q.size() > 0) e = rx_q.pop_front();
        else begin e = 8'h00; m_udf = 1; end
        chk("rd_data", q, e);
        chk("irq", irq, exp_irq());
    endtask

    task automatic rd_status();
        logic [7:0] q, e;
        bus(1'b0, 2'd1, 8'h00, q);
        e = {2'b00, m_udf, m_ovf, rx_q.size() == 0, rx_q.size() == DEPTH,
             tx_q.size() == 0, tx_q.size() == DEPTH};
        chk("rd_status", q, e);
    endtask

    task automatic rd_ctrl();
        logic [7:0] q;
        bus(1'b0, 2'd2, 8'h00, q);
        chk("rd_ctrl", q, {4'b0, m_ie_rx, m_ie_tx, 2'b00});
    endtask

    task automatic rd_count();
        logic [7:0] q;
        bus(1'b0, 2'd3, 8'h00, q);
        chk("rd_count", q, rx_q.size());
    endtask

    task automatic wr_status(input logic [7:0] b);
        logic [7:0] q;
        bus(1'b1, 2'd1, b, q);
        if (b[4]) m_ovf = 0;
        if (b[5]) m_udf = 0;
    endtask

    task automatic wr_ctrl(input logic [7:0] b);
        logic [7:0] q;
        bus(1'b1, 2'd2, b, q);
        if (b[0]) tx_q.delete();
        if (b[1]) rx_q.delete();
        if (IRQ_BUILD) begin
            m_ie_tx = b[2];
            m_ie_rx = b[3];
        end
        chk("irq", irq, exp_irq());
    endtask

    task automatic rx_push(input logic [7:0] b);
        chk("rx_ready", rx_ready, rx_q.size() < DEPTH);
        rx_data = b; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
        tick();
        chk("irq", irq, exp_irq());
    endtask

    task automatic tx_pop();
        chk("tx_valid", tx_valid, tx_q.size() > 0);
        if (tx_q.size() > 0) chk("tx_data", tx_data, tx_q[0]);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        if (tx_q.size() > 0) void'(tx_q.pop_front());
        tick();
        chk("irq", irq, exp_irq());
    endtask

    initial begin
        logic [7:0] b;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_ack", ack, 0);
        chk("rst_dat", dat_o, 8'h00);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_irq", irq, 0);

        // Reset asserted while an ACK is on the bus.
        wr_data(8'h11);
        rx_push(8'h22);
        cyc = 1'b1; stb = 1'b1; we_i = 1'b0; adr = BASE + 8'd1;
        tick();
        chk("t1_ack_pre", ack, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_ack_async", ack, 0);
        chk("t1_tx_valid", tx_valid, 0);
        chk("t1_rx_ready", rx_ready, 1);
        cyc = 1'b0; stb = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tx_q.delete(); rx_q.delete();
        m_ovf = 0; m_udf = 0; m_ie_tx = 0; m_ie_rx = 0;
        tick();
        rd_status();

        // Two writes drained in order.
        wr_data(8'hA5);
        wr_data(8'h3C);
        chk("t2_head", tx_data, 8'hA5);
        tx_pop();
        tx_pop();
        chk("t2_tx_valid", tx_valid, 0);

        // TX overflow and sticky clear.
        for (int i = 0; i < DEPTH + 1; i++) wr_data(8'($urandom));
        rd_status();
        wr_status(8'h10);
        rd_status();
        wr_ctrl(8'h01);

        // RX fill beyond full, then read past empty.
        for (int i = 0; i < DEPTH + 1; i++) rx_push(8'($urandom));
        chk("t4_rx_ready", rx_ready, 0);
        rd_count();
        for (int i = 0; i < DEPTH + 1; i++) rd_data();
        rd_status();
        wr_status(8'h20);
        rd_status();

        // TX flush beats a same-cycle consumer handshake.
        for (int i = 0; i < 5; i++) wr_data(8'(i + 1));
        chk("t5_tx_valid_pre", tx_valid, 1);
        tx_ready = 1'b1;
        wr_ctrl(8'h01);
        chk("t5_tx_valid", tx_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_tx_stays_empty", tx_valid, 0);
        end
        tx_ready = 1'b0;

        // RX flush discards a byte handshaken in the flush cycle.
        for (int i = 0; i < 3; i++) rx_push(8'(8'h40 + i));
        rx_data = 8'h77; rx_valid = 1'b1;
        cyc = 1'b1; stb = 1'b1; we_i = 1'b1; adr = BASE + 8'd2; dat = 8'h02;
        tick();
        rx_valid = 1'b0;
        chk("t5_rx_ack", ack, 1);
        cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
        tick();
        rx_q.delete();
        rd_count();
        chk("t5_rx_ready", rx_ready, 1);

        // Addresses outside the block never acknowledge.
        for (int a = 0; a < 2; a++) begin
            cyc = 1'b1; stb = 1'b1; we_i = 1'b1; dat = 8'hEE;
            adr = (a == 0) ? 8'h7F : 8'h84;
            for (int c = 0; c < 4; c++) begin
                tick();
                chk("miss_no_ack", ack, 0);
            end
            cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
            tick();
        end
        rd_status();

        // Interrupt enables.
        wr_ctrl(8'h08);
        rx_push(8'h5A);
        chk("t6_irq_on", irq, IRQ_BUILD);
        rd_data();
        chk("t6_irq_off", irq, 0);
        wr_ctrl(8'h04);
        chk("t6_irq_tx_empty", irq, IRQ_BUILD);
        rd_ctrl();
        wr_ctrl(8'h00);

        // Random mix of bus and stream operations.
        for (int n = 0; n < 300; n++) begin
            b = 8'($urandom);
            case ($urandom_range(0, 7))
                0: wr_data(b);
                1: rd_data();
                2: rd_status();
                3: rd_count();
                4: rx_push(b);
                5: tx_pop();
                6: wr_status(b);
                default: if (b[7:5] == 3'b000) wr_ctrl(b); else rd_ctrl();
            endcase
        end
        rd_status();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
